// File: rtl/wm_pkg.sv
// Shared washing-machine types: coin denomination codes with their credit
// values, the acceptor state encoding and the default wash price.
package wm_pkg;

  localparam int unsigned PRICE_DEFAULT = 4;

  // Width of a single coin's credit value (largest coin is 5 units).
  localparam int unsigned VALUE_W = 3;

  typedef enum logic [1:0] {
    DENOM_NONE = 2'b00,
    DENOM_ONE  = 2'b01,
    DENOM_TWO  = 2'b10,
    DENOM_FIVE = 2'b11
  } denom_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE_DB = 3'd1,
    ST_HOLD    = 3'd2,
    ST_FALL_DB = 3'd3,
    ST_REFUND  = 3'd4
  } acc_state_t;

  // Credit units carried by a denomination code.
  function automatic logic [VALUE_W-1:0] denom_value(input denom_t code);
    logic [VALUE_W-1:0] value;
    value = '0;
    case (code)
      DENOM_ONE:  value = VALUE_W'(1);
      DENOM_TWO:  value = VALUE_W'(2);
      DENOM_FIVE: value = VALUE_W'(5);
      default:    value = '0;
    endcase
    return value;
  endfunction

  function automatic logic denom_valid(input denom_t code);
    return code != DENOM_NONE;
  endfunction

endpackage

// File: rtl/coin_debouncer.sv
// Coin sensor debouncer: qualifies a rising coin edge after DEBOUNCE
// consecutive high samples and a release after DEBOUNCE consecutive lows.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   sense         - raw coin sensor level
//   freeze        - forces the debouncer idle and drops any partial count
//   coin_edge_c   - combinational strobe, high in the cycle whose closing
//                   edge takes the DEBOUNCE-th consecutive high sample
//   released      - registered, high while no coin is being qualified/held
module coin_debouncer
  import wm_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sense,
  input  logic freeze,
  output logic coin_edge_c,
  output logic released
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  acc_state_t       state;
  acc_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             released_next;

  // State, counter and release flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      released <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      released <= released_next;
    end
  end

  // Next state: the sample that enters RISE_DB/FALL_DB counts as the first.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (freeze) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sense) begin
            state_next = ST_RISE_DB;
            cnt_next   = CNT_W'(1);
          end
        end
        ST_RISE_DB: begin
          if (!sense) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = ST_HOLD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!sense) begin
            state_next = ST_FALL_DB;
            cnt_next   = CNT_W'(1);
          end
        end
        ST_FALL_DB: begin
          if (sense) begin
            state_next = ST_HOLD;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs: edge strobe for the accept edge, release flag for the next cycle.
  always_comb begin
    coin_edge_c   = 1'b0;
    released_next = (state_next == ST_IDLE);
    if (!freeze && (state == ST_RISE_DB) && sense && (cnt == CNT_LAST)) begin
      coin_edge_c = 1'b1;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the coin chute, accumulates credit, consumes the
// wash price on start and refunds all credit as paced eject pulses.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   coin_Sense     - raw coin sensor level
//   coin_Denom     - denomination code sampled on the accept edge
//   coin_Return    - refund request pulse (highest priority)
//   start          - consume-PRICE request pulse
//   sig_Coin       - registered credit >= PRICE
//   credit         - registered credit
//   accept_Enable  - chute gate open, low during refund
//   reject_Coin    - one-cycle pulse for a refused coin
//   eject_Pulse    - one-cycle pulse per refunded unit
//   busy           - high while refunding
module coin_acceptor
  import wm_pkg::*;
#(
  parameter int unsigned PRICE      = PRICE_DEFAULT,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned REFUND_GAP = 8,
  localparam int unsigned CREDIT_W  = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_Sense,
  input  logic [1:0]          coin_Denom,
  input  logic                coin_Return,
  input  logic                start,
  output logic                sig_Coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                accept_Enable,
  output logic                reject_Coin,
  output logic                eject_Pulse,
  output logic                busy
);

  // Sum width holds credit plus the largest coin without overflow.
  localparam int unsigned SUM_W = CREDIT_W + VALUE_W;
  localparam int unsigned GAP_W = $clog2(REFUND_GAP + 1);

  acc_state_t          state;
  acc_state_t          state_next;
  logic [GAP_W-1:0]    gap_cnt;
  logic [GAP_W-1:0]    gap_next;
  logic [CREDIT_W-1:0] credit_next;
  logic                sig_next;
  logic                accept_next;
  logic                reject_next;
  logic                eject_next;
  logic                busy_next;

  logic                coin_edge_c;
  logic                released;
  logic                take_return_c;
  logic                take_start_c;
  logic                freeze_c;
  logic [VALUE_W-1:0]  value_c;
  logic [SUM_W-1:0]    base_c;
  logic [SUM_W-1:0]    sum_c;

  // Request qualification against the registered credit.
  always_comb begin
    take_return_c = (state == ST_IDLE) && coin_Return && (credit != '0);
    take_start_c  = (state == ST_IDLE) && !take_return_c && start &&
                    (SUM_W'(credit) >= SUM_W'(PRICE));
    // Freeze on the entry edge too, so an in-flight count is dropped at once.
    freeze_c      = (state == ST_REFUND) || take_return_c;
  end

  coin_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debouncer (
    .clock       (clock),
    .reset       (reset),
    .sense       (coin_Sense),
    .freeze      (freeze_c),
    .coin_edge_c (coin_edge_c),
    .released    (released)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave REFUND once credit is drained and the gap has elapsed.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (take_return_c) begin
          state_next = ST_REFUND;
        end
      end
      ST_REFUND: begin
        if ((gap_cnt == '0) && (credit == '0) && released) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Credit datapath and next output values.
  always_comb begin
    credit_next = credit;
    gap_next    = gap_cnt;
    reject_next = 1'b0;
    eject_next  = 1'b0;
    value_c     = denom_value(denom_t'(coin_Denom));
    base_c      = '0;
    sum_c       = '0;
    case (state)
      ST_REFUND: begin
        if (gap_cnt == '0) begin
          if (credit != '0) begin
            eject_next  = 1'b1;
            credit_next = credit - CREDIT_W'(1);
            gap_next    = GAP_W'(REFUND_GAP);
          end
        end else begin
          gap_next = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        if (take_return_c) begin
          // First eject lands on the edge after entry.
          gap_next = '0;
        end else begin
          // Start is charged before the coin so saturation sees the net credit.
          base_c      = SUM_W'(credit) - (take_start_c ? SUM_W'(PRICE) : '0);
          sum_c       = base_c + SUM_W'(value_c);
          credit_next = CREDIT_W'(base_c);
          if (coin_edge_c) begin
            if (denom_valid(denom_t'(coin_Denom)) &&
                (sum_c <= SUM_W'(MAX_CREDIT))) begin
              credit_next = CREDIT_W'(sum_c);
            end else begin
              reject_next = 1'b1;
            end
          end
        end
      end
    endcase
    busy_next   = (state_next == ST_REFUND);
    accept_next = !busy_next;
    sig_next    = SUM_W'(credit_next) >= SUM_W'(PRICE);
  end

  // Registered outputs and refund pacing counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit        <= '0;
      gap_cnt       <= '0;
      sig_Coin      <= 1'b0;
      accept_Enable <= 1'b1;
      reject_Coin   <= 1'b0;
      eject_Pulse   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      credit        <= credit_next;
      gap_cnt       <= gap_next;
      sig_Coin      <= sig_next;
      accept_Enable <= accept_next;
      reject_Coin   <= reject_next;
      eject_Pulse   <= eject_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: a run-length/schedule model checked
// every cycle, plus hand-computed literal checkpoints.
module tb_coin_acceptor;

  localparam int PRICE      = 4;
  localparam int MAX_CREDIT = 15;
  localparam int DEBOUNCE   = 4;
  localparam int REFUND_GAP = 8;

  logic       clock       = 1'b0;
  logic       reset       = 1'b1;
  logic       coin_Sense  = 1'b0;
  logic [1:0] coin_Denom  = 2'b00;
  logic       coin_Return = 1'b0;
  logic       start       = 1'b0;
  logic       sig_Coin;
  logic [3:0] credit;
  logic       accept_Enable;
  logic       reject_Coin;
  logic       eject_Pulse;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  coin_acceptor dut (
    .clock         (clock),
    .reset         (reset),
    .coin_Sense    (coin_Sense),
    .coin_Denom    (coin_Denom),
    .coin_Return   (coin_Return),
    .start         (start),
    .sig_Coin      (sig_Coin),
    .credit        (credit),
    .accept_Enable (accept_Enable),
    .reject_Coin   (reject_Coin),
    .eject_Pulse   (eject_Pulse),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int val_tab [4] = '{0, 1, 2, 5};
  int cyc      = 0;
  int run_hi   = 0;
  int run_lo   = 0;
  bit latched  = 1'b0;
  bit m_refund = 1'b0;
  bit m_valid  = 1'b0;
  int t0       = 0;
  int n_ref    = 0;
  int k        = 0;
  int base     = 0;
  int v        = 0;
  int m_credit = 0;
  bit m_reject = 1'b0;
  bit m_eject  = 1'b0;

  always @(posedge clock) begin
    cyc++;
    m_reject = 1'b0;
    m_eject  = 1'b0;
    if (reset) begin
      m_valid  = 1'b1;
      m_refund = 1'b0;
      m_credit = 0;
      run_hi   = 0;
      run_lo   = 0;
      latched  = 1'b0;
    end else if (m_refund) begin
      // Refund schedule: pulse j at entry+1+j*(GAP+1), exit GAP+1 after last.
      k = cyc - t0;
      if (k == 1 + n_ref * (REFUND_GAP + 1)) begin
        m_refund = 1'b0;
        m_credit = 0;
      end else if ((k - 1) % (REFUND_GAP + 1) == 0) begin
        m_eject  = 1'b1;
        m_credit = n_ref - ((k - 1) / (REFUND_GAP + 1) + 1);
      end
      run_hi  = 0;
      run_lo  = 0;
      latched = 1'b0;
    end else if (coin_Return && m_credit > 0) begin
      m_refund = 1'b1;
      t0       = cyc;
      n_ref    = m_credit;
      run_hi   = 0;
      run_lo   = 0;
      latched  = 1'b0;
    end else begin
      base = m_credit;
      if (start && m_credit >= PRICE) base = base - PRICE;
      if (coin_Sense) begin
        run_hi++;
        run_lo = 0;
      end else begin
        run_lo++;
        run_hi = 0;
      end
      if (latched && run_lo == DEBOUNCE) latched = 1'b0;
      if (!latched && run_hi == DEBOUNCE) begin
        latched = 1'b1;
        v = val_tab[coin_Denom];
        if (coin_Denom == 2'b00 || base + v > MAX_CREDIT) m_reject = 1'b1;
        else base = base + v;
      end
      m_credit = base;
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      lit("cyc credit",  int'(credit),        m_credit);
      lit("cyc sig",     int'(sig_Coin),      int'(m_credit >= PRICE));
      lit("cyc accept",  int'(accept_Enable), int'(!m_refund));
      lit("cyc busy",    int'(busy),          int'(m_refund));
      lit("cyc reject",  int'(reject_Coin),   int'(m_reject));
      lit("cyc eject",   int'(eject_Pulse),   int'(m_eject));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic coin(input logic [1:0] code, input int highs, input int lows);
    coin_Denom = code;
    coin_Sense = 1'b1;
    step(highs);
    coin_Sense = 1'b0;
    step(lows);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_return();
    coin_Return = 1'b1;
    step(1);
    coin_Return = 1'b0;
  endtask

  // Pin both DUT and model to a hand-computed value.
  task automatic pin(input string name, input int dut_v, input int mdl_v, input int exp);
    lit({name, " dut"}, dut_v, exp);
    lit({name, " model"}, mdl_v, exp);
  endtask

  initial begin
    reset = 1'b1;
    step(2);
    pin("rst credit", int'(credit), m_credit, 0);
    pin("rst sig", int'(sig_Coin), int'(m_credit >= PRICE), 0);
    lit("rst accept", int'(accept_Enable), 1);
    lit("rst eject", int'(eject_Pulse), 0);
    lit("rst reject", int'(reject_Coin), 0);
    lit("rst busy", int'(busy), 0);
    reset = 1'b0;

    // Glitch of 3 high samples is not a coin.
    coin(2'b10, 3, 4);
    pin("glitch credit", int'(credit), m_credit, 0);

    // Real coin: credit appears after the 4th high sample.
    coin_Denom = 2'b10;
    coin_Sense = 1'b1;
    step(3);
    pin("pre-accept credit", int'(credit), m_credit, 0);
    step(1);
    pin("accept credit", int'(credit), m_credit, 2);
    // Bounce back in before a full release: not counted again.
    coin_Sense = 1'b0;
    step(2);
    coin_Sense = 1'b1;
    step(4);
    coin_Sense = 1'b0;
    step(4);
    pin("reinsert credit", int'(credit), m_credit, 2);

    coin(2'b10, 4, 4);
    pin("two coins credit", int'(credit), m_credit, 4);
    lit("two coins sig", int'(sig_Coin), 1);
    pulse_start();
    pin("start credit", int'(credit), m_credit, 0);
    lit("start sig", int'(sig_Coin), 0);

    coin(2'b01, 4, 4);
    coin(2'b10, 4, 4);
    pulse_start();
    pin("low start credit", int'(credit), m_credit, 3);

    coin(2'b11, 4, 4);
    coin(2'b11, 4, 4);
    coin(2'b01, 4, 4);
    pin("build credit", int'(credit), m_credit, 14);

    // Overflowing coin is refused.
    coin_Denom = 2'b11;
    coin_Sense = 1'b1;
    step(4);
    pin("sat reject", int'(reject_Coin), int'(m_reject), 1);
    pin("sat credit", int'(credit), m_credit, 14);
    coin_Sense = 1'b0;
    step(1);
    lit("sat reject drop", int'(reject_Coin), 0);
    step(3);

    // Invalid code is refused.
    coin_Denom = 2'b00;
    coin_Sense = 1'b1;
    step(4);
    pin("bad code reject", int'(reject_Coin), int'(m_reject), 1);
    pin("bad code credit", int'(credit), m_credit, 14);
    coin_Sense = 1'b0;
    step(4);

    pulse_start();
    pulse_start();
    pulse_start();
    coin(2'b01, 4, 4);
    pin("pre-refund credit", int'(credit), m_credit, 3);

    // Refund of 3 units, with a coin and a start thrown in.
    pulse_return();
    lit("refund busy", int'(busy), 1);
    lit("refund gate", int'(accept_Enable), 0);
    pin("refund entry credit", int'(credit), m_credit, 3);
    step(1);
    pin("eject 1", int'(eject_Pulse), int'(m_eject), 1);
    pin("eject 1 credit", int'(credit), m_credit, 2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    coin_Denom = 2'b10;
    coin_Sense = 1'b1;
    step(5);
    coin_Sense = 1'b0;
    step(2);
    lit("gap no eject", int'(eject_Pulse), 0);
    pin("gap credit", int'(credit), m_credit, 2);
    step(1);
    pin("eject 2", int'(eject_Pulse), int'(m_eject), 1);
    pin("eject 2 credit", int'(credit), m_credit, 1);
    step(9);
    pin("eject 3", int'(eject_Pulse), int'(m_eject), 1);
    pin("eject 3 credit", int'(credit), m_credit, 0);
    step(8);
    lit("tail busy", int'(busy), 1);
    lit("tail gate", int'(accept_Enable), 0);
    step(1);
    lit("exit busy", int'(busy), 0);
    lit("exit gate", int'(accept_Enable), 1);

    // Coin accept edge and start on the same edge.
    coin(2'b01, 4, 4);
    coin(2'b10, 4, 4);
    coin_Denom = 2'b11;
    coin_Sense = 1'b1;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    pin("start+coin at 3", int'(credit), m_credit, 8);
    coin_Sense = 1'b0;
    step(4);
    pulse_start();
    pin("back to 4", int'(credit), m_credit, 4);
    coin_Denom = 2'b11;
    coin_Sense = 1'b1;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    pin("start+coin at 4", int'(credit), m_credit, 5);
    lit("start+coin sig", int'(sig_Coin), 1);
    coin_Sense = 1'b0;
    step(4);

    // Reset in the middle of a refund.
    pulse_return();
    step(1);
    pin("mid eject", int'(eject_Pulse), int'(m_eject), 1);
    pin("mid credit", int'(credit), m_credit, 4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    pin("mid rst credit", int'(credit), m_credit, 0);
    lit("mid rst busy", int'(busy), 0);
    lit("mid rst gate", int'(accept_Enable), 1);
    step(20);
    lit("after rst eject", int'(eject_Pulse), 0);

    // Exactly reaching the ceiling is allowed; one more unit is refused.
    coin(2'b11, 4, 4);
    coin(2'b11, 4, 4);
    coin(2'b11, 4, 4);
    pin("ceiling credit", int'(credit), m_credit, 15);
    coin_Denom = 2'b01;
    coin_Sense = 1'b1;
    step(4);
    pin("over ceiling reject", int'(reject_Coin), int'(m_reject), 1);
    pin("over ceiling credit", int'(credit), m_credit, 15);
    coin_Sense = 1'b0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
